// File: rtl/bound_flasher_ctrl.sv
// Bound flasher sequencer: steers an external 4-bit up/down counter through
// 0->15->LOW_B->MID_B->0 and drives a 16-lamp thermometer of its value.
module bound_flasher_ctrl #(
    parameter logic [3:0] LOW_B = 4'd5,
    parameter logic [3:0] MID_B = 4'd10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flick,
    input  logic [3:0]  count,
    output logic        upcount,
    output logic        enable,
    output logic [15:0] lamps,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        UP1  = 3'd1,
        DN1  = 3'd2,
        UP2  = 3'd3,
        DN2  = 3'd4
    } state_t;

    localparam logic [3:0] TOP    = 4'd15;
    localparam logic [3:0] BOTTOM = 4'd0;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Each leg stops stepping at its target, so the counter dwells there for
    // one cycle and can never be asked to wrap past 15 or 0.
    always_comb begin
        state_nxt = IDLE;
        upcount   = 1'b0;
        enable    = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = flick ? UP1 : IDLE;
            end
            UP1: begin
                upcount = 1'b1;
                enable  = (count != TOP);
                if (flick && (count == LOW_B || count == MID_B)) begin
                    state_nxt = DN2;
                end else if (count == TOP) begin
                    state_nxt = DN1;
                end else begin
                    state_nxt = UP1;
                end
            end
            DN1: begin
                upcount   = 1'b0;
                enable    = (count != LOW_B);
                state_nxt = (count == LOW_B) ? UP2 : DN1;
            end
            UP2: begin
                upcount = 1'b1;
                enable  = (count != MID_B);
                if (flick && count == LOW_B) begin
                    state_nxt = DN1;
                end else if (count == MID_B) begin
                    state_nxt = DN2;
                end else begin
                    state_nxt = UP2;
                end
            end
            DN2: begin
                upcount = 1'b0;
                enable  = (count != BOTTOM);
                if (count == BOTTOM) begin
                    state_nxt = flick ? UP1 : IDLE;
                end else begin
                    state_nxt = DN2;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_comb begin
        lamps = '0;
        for (int i = 0; i < 16; i++) begin
            lamps[i] = busy && (4'(i) <= count);
        end
    end

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// Self-checking bench for bound_flasher_ctrl: a behavioural up/down counter
// closes the loop, and per-cycle expected outputs come from a scoreboard queue.
module tb_bound_flasher_ctrl;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_UP1  = 3'd1;
    localparam logic [2:0] S_DN1  = 3'd2;
    localparam logic [2:0] S_UP2  = 3'd3;
    localparam logic [2:0] S_DN2  = 3'd4;

    logic        clk;
    logic        reset;
    logic        flick;
    logic [3:0]  count;
    logic        upcount;
    logic        enable;
    logic [15:0] lamps;
    logic        busy;
    logic [2:0]  dbg_state;

    // Scoreboard entry: {state, busy, upcount, enable, count}
    logic [9:0] exp_q[$];
    logic       flick_q[$];
    int         n_vec;
    int         n_bad;

    bound_flasher_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .flick     (flick),
        .count     (count),
        .upcount   (upcount),
        .enable    (enable),
        .lamps     (lamps),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset / external counter ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= 4'd0;
        end else if (enable) begin
            count <= upcount ? count + 4'd1 : count - 4'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] therm(input logic on, input logic [3:0] c);
        logic [31:0] t;
        t = (32'h1 << (int'(c) + 1)) - 32'h1;
        return on ? t[15:0] : 16'h0000;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic push_e(input logic [2:0] st, input logic up, input logic en, input logic [3:0] c);
        exp_q.push_back({st, (st != S_IDLE), up, en, c});
    endtask

    task automatic push_steps(input logic [2:0] st, input logic up, input int a, input int b);
        if (up) begin
            for (int v = a; v <= b; v++) push_e(st, 1'b1, 1'b1, 4'(v));
        end else begin
            for (int v = a; v >= b; v--) push_e(st, 1'b0, 1'b1, 4'(v));
        end
    endtask

    task automatic push_dwell(input logic [2:0] st, input logic up, input int v);
        push_e(st, up, 1'b0, 4'(v));
    endtask

    task automatic zero_flicks();
        flick_q.delete();
        for (int i = 0; i < exp_q.size(); i++) flick_q.push_back(1'b0);
    endtask

    // Pops one expected entry per cycle; flick for the following edge is
    // applied on the same negedge the outputs are sampled.
    task automatic run_queue(input string tag);
        logic [9:0]  e;
        logic [25:0] got;
        logic [25:0] want;
        logic [3:0]  prev_c;
        logic        wrap;
        logic        first;
        wrap  = 1'b0;
        first = 1'b1;
        prev_c = 4'd0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            flick = (flick_q.size() > 0) ? flick_q.pop_front() : 1'b0;
            e    = exp_q.pop_front();
            got  = {dbg_state, busy, upcount, enable, count, lamps};
            want = {e, therm(e[6], e[3:0])};
            check_val(tag, 32'(got), 32'(want));
            if (!first && ((prev_c == 4'd15 && count == 4'd0) || (prev_c == 4'd0 && count == 4'd15)))
                wrap = 1'b1;
            prev_c = count;
            first  = 1'b0;
        end
        check_val({tag, "_nowrap"}, 32'(wrap), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        n_vec = 0;
        n_bad = 0;
        reset = 1'b1;
        flick = 1'b0;
        #2;
        check_val("reset_hold", 32'({dbg_state, busy, upcount, enable, lamps, count}), 32'd0);
        #10;
        reset = 1'b0;

        // Idle with no flick
        for (int i = 0; i < 10; i++) push_dwell(S_IDLE, 1'b0, 0);
        zero_flicks();
        run_queue("idle");

        // Single pulse: full pattern
        push_dwell(S_IDLE, 1'b0, 0);
        push_steps(S_UP1, 1'b1, 0, 14);
        push_dwell(S_UP1, 1'b1, 15);
        push_steps(S_DN1, 1'b0, 15, 6);
        push_dwell(S_DN1, 1'b0, 5);
        push_steps(S_UP2, 1'b1, 5, 9);
        push_dwell(S_UP2, 1'b1, 10);
        push_steps(S_DN2, 1'b0, 10, 1);
        push_dwell(S_DN2, 1'b0, 0);
        push_dwell(S_IDLE, 1'b0, 0);
        push_dwell(S_IDLE, 1'b0, 0);
        zero_flicks();
        flick_q[0] = 1'b1;
        run_queue("pulse");

        // Kickback in UP1 at LOW_B
        push_dwell(S_IDLE, 1'b0, 0);
        push_steps(S_UP1, 1'b1, 0, 4);
        k = exp_q.size();
        push_steps(S_UP1, 1'b1, 5, 5);
        push_steps(S_DN2, 1'b0, 6, 1);
        push_dwell(S_DN2, 1'b0, 0);
        push_dwell(S_IDLE, 1'b0, 0);
        zero_flicks();
        flick_q[0] = 1'b1;
        flick_q[k] = 1'b1;
        run_queue("kick_up1");

        // Kickback in UP2 at LOW_B
        push_dwell(S_IDLE, 1'b0, 0);
        push_steps(S_UP1, 1'b1, 0, 14);
        push_dwell(S_UP1, 1'b1, 15);
        push_steps(S_DN1, 1'b0, 15, 6);
        push_dwell(S_DN1, 1'b0, 5);
        k = exp_q.size();
        push_steps(S_UP2, 1'b1, 5, 5);
        push_steps(S_DN1, 1'b0, 6, 6);
        push_dwell(S_DN1, 1'b0, 5);
        push_steps(S_UP2, 1'b1, 5, 9);
        push_dwell(S_UP2, 1'b1, 10);
        push_steps(S_DN2, 1'b0, 10, 1);
        push_dwell(S_DN2, 1'b0, 0);
        push_dwell(S_IDLE, 1'b0, 0);
        zero_flicks();
        flick_q[0] = 1'b1;
        flick_q[k] = 1'b1;
        run_queue("kick_up2");

        // flick held high: 0..5 then back down, restarting from 0 each time
        push_dwell(S_IDLE, 1'b0, 0);
        for (int p = 0; p < 8; p++) begin
            push_steps(S_UP1, 1'b1, 0, 5);
            push_steps(S_DN2, 1'b0, 6, 1);
            k = exp_q.size();
            push_dwell(S_DN2, 1'b0, 0);
        end
        push_dwell(S_IDLE, 1'b0, 0);
        flick_q.delete();
        for (int i = 0; i < exp_q.size(); i++) flick_q.push_back(i < k);
        run_queue("held");

        // Async reset mid-UP1 at count 9, between edges
        push_dwell(S_IDLE, 1'b0, 0);
        push_steps(S_UP1, 1'b1, 0, 9);
        zero_flicks();
        flick_q[0] = 1'b1;
        run_queue("pre_rst");
        #1;
        reset = 1'b1;
        #1;
        check_val("async_rst", 32'({dbg_state, busy, upcount, enable, lamps, count}), 32'd0);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) push_dwell(S_IDLE, 1'b0, 0);
        zero_flicks();
        run_queue("post_rst");

        // Random short flick pulses while idle-waiting: only first starts a run
        push_dwell(S_IDLE, 1'b0, 0);
        push_steps(S_UP1, 1'b1, 0, 3);
        zero_flicks();
        flick_q[0] = 1'b1;
        for (int i = 1; i < flick_q.size(); i++) flick_q[i] = ($urandom_range(0, 1) == 1);
        run_queue("rand_start");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
